ext_share_arbiter: RTL and testbench
====================================

Name: ext_share_arbiter

Overview:
- Shares one immediate sign/zero-extension datapath among NUM_REQ requesters, e.g. decode-stage immediates and the load-byte/halfword alignment path.
- Arbitration is round-robin.
- Requests and responses use valid/ready handshakes.
- The extended result is held in a one-deep output register, tagged with the requester ID.
- Sits between the ID/MEM control logic and the shared extension datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IMM_W, 16, immediate input width.
- OUT_W, 32, extended output width (must be greater than IMM_W).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_imm  in  NUM_REQ*IMM_W  packed immediates; requester i uses bits [i*IMM_W +: IMM_W].
- req_signext  in  NUM_REQ  per requester: 1 = sign extend, 0 = zero extend.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- rsp_valid  out  1  result register holds valid data.
- rsp_data  out  OUT_W  extended result.
- rsp_id  out  ID_W  index of the requester that produced rsp_data; ID_W = max(1, clog2(NUM_REQ)).
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (Reset==0 at a clock edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - State=EMPTY.
  - req_ready is 0 while Reset==0.
- States:
  - EMPTY: output register holds no valid data.
  - FULL: rsp_valid=1; data held stable until a handshake completes.
- can_accept = (state==EMPTY) || rsp_ready.
- Grant selection (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is gnt.
  - req_ready[gnt] = can_accept; every other bit is 0.
  - If no request is valid, req_ready is all zero.
- Transfer: occurs when req_valid[gnt] && req_ready[gnt]. On that edge:
  - rsp_data <= extend(req_imm[gnt], req_signext[gnt]).
  - rsp_id <= gnt.
  - rsp_valid <= 1.
  - rr_ptr <= (gnt+1) mod NUM_REQ.
- extend():
  - Low IMM_W bits = imm.
  - Upper OUT_W-IMM_W bits are replicated imm[IMM_W-1] if signext=1, otherwise 0.
- Latency: 1 cycle from accepted request to rsp_valid.
- Throughput: 1 per cycle when rsp_ready is held high (same-cycle drain and refill).
- Transitions:
  - EMPTY->FULL on a transfer.
  - FULL->EMPTY on rsp_ready with no transfer.
  - FULL->FULL on rsp_ready with a transfer (new data replaces old).
  - FULL stays FULL with data held if rsp_ready=0.
- Backpressure: in FULL with rsp_ready=0:
  - rsp_data and rsp_id must not change.
  - req_ready is all zero.
  - rr_ptr is unchanged.
- rr_ptr advances only on a transfer, never on idle cycles.
- Requester rules:
  - A requester holds its request valid and stable until it sees req_ready.
  - The arbiter does not require this; a withdrawn request is simply not granted.
- Reset mid-operation: a pending response is discarded and the result register returns to reset values.

Optional Feature:
- Macro: EXT_LUI_EN.
- Enabled:
  - Adds input port req_lui [NUM_REQ].
  - When req_lui[gnt]=1, the result is {imm, (OUT_W-IMM_W) zeros} and req_signext is ignored.
- Disabled:
  - Port is absent.
  - Behaviour is exactly as above.

Decomposition:
- Package ext_arb_pkg:
  - IMM_W / OUT_W defaults.
  - Function computing ID_W.
  - State enum {EMPTY, FULL}.
  - Function rr_pick(valid, ptr) returning the granted index.
- Sub-module imm_ext_core:
  - Combinational extender: inputs imm, signext (and lui under EXT_LUI_EN); output OUT_W result.
  - Instantiated once, fed by the grant mux.

Test Plan:
- Reset then idle: Reset=0 for 2 cycles, then req_valid=0 -> rsp_valid=0, rsp_data=0, req_ready=00, rr_ptr stays 0.
- Single sign-extend:
  - Stimulus: req0 imm=16'h8001, signext=1, rsp_ready=1.
  - Required: next cycle rsp_data=32'hFFFF8001, rsp_id=0.
  - Same test with signext=0 -> rsp_data=32'h00008001.
- Round-robin fairness:
  - Stimulus: both requesters valid continuously, rsp_ready=1.
  - Required: grants alternate 0,1,0,1; results appear back-to-back with no bubble.
- Backpressure:
  - Stimulus: req1 imm=16'h7FFF, signext=1, with rsp_ready=0 for 3 cycles.
  - Required: rsp_data=32'h00007FFF held; rsp_valid=1; req_ready=00 throughout.
  - Then raise rsp_ready with req0 pending -> same-cycle drain and refill.
- Reset mid-operation: FULL with rsp_ready=0, assert Reset=0 -> next edge rsp_valid=0, rsp_data=0, rr_ptr=0.
- EXT_LUI_EN build: req0 imm=16'h1234, lui=1, signext=1 -> rsp_data=32'h12340000.

Source files
------------

// File: rtl/ext_arb_pkg.sv
// ----------------------------------------------------------------------------
// ext_arb_pkg
// Shared definitions for the immediate-extension arbiter:
//   - default immediate / result widths
//   - calc_id_w(): width of a requester index (at least 1 bit)
//   - state_e: output-register occupancy state
//   - rr_pick(): round-robin search over up to 8 requesters
// No ports (package).
// ----------------------------------------------------------------------------
package ext_arb_pkg;

    localparam int IMM_W_DEF = 16;
    localparam int OUT_W_DEF = 32;
    localparam int MAX_REQ   = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Returns the first set bit of valid, searching upward from ptr and
    // wrapping modulo n. Only meaningful when at least one bit of
    // valid[n-1:0] is set; otherwise returns 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] res;
        logic       found;
        int         cand;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            cand = (int'(ptr) + i) % n;
            if (!found && (i < n) && valid[cand[2:0]]) begin
                res   = cand[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// ----------------------------------------------------------------------------
// imm_ext_core
// Combinational immediate extender shared by all requesters.
//   imm_i      [IMM_W]  immediate to extend
//   signext_i  [1]      1 = sign extend, 0 = zero extend
//   lui_i      [1]      (EXT_LUI_EN builds only) place imm in the upper bits
//   result_o   [OUT_W]  extended value
// Optional feature macro: EXT_LUI_EN.
// ----------------------------------------------------------------------------
module imm_ext_core #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic [IMM_W-1:0] imm_i,
    input  logic             signext_i,
`ifdef EXT_LUI_EN
    input  logic             lui_i,
`endif
    output logic [OUT_W-1:0] result_o
);

    logic fill_bit;

    assign fill_bit = signext_i & imm_i[IMM_W-1];

`ifdef EXT_LUI_EN
    // Upper-immediate form overrides the sign/zero choice entirely.
    assign result_o = lui_i ? {imm_i, {(OUT_W-IMM_W){1'b0}}}
                            : {{(OUT_W-IMM_W){fill_bit}}, imm_i};
`else
    assign result_o = {{(OUT_W-IMM_W){fill_bit}}, imm_i};
`endif

endmodule

// File: rtl/ext_share_arbiter.sv
// ----------------------------------------------------------------------------
// ext_share_arbiter
// Round-robin arbiter sharing one immediate extender among NUM_REQ
// requesters, with a one-deep tagged output register.
//   Clk           [1]              rising-edge clock
//   Reset         [1]              synchronous, active-low reset
//   req_valid     [NUM_REQ]        per-requester request valid
//   req_imm       [NUM_REQ*IMM_W]  packed immediates, slot i at [i*IMM_W +: IMM_W]
//   req_signext   [NUM_REQ]        1 = sign extend, 0 = zero extend
//   req_lui       [NUM_REQ]        (EXT_LUI_EN builds only) upper-immediate form
//   req_ready     [NUM_REQ]        one-hot accept strobe
//   rsp_valid     [1]              result register holds valid data
//   rsp_data      [OUT_W]          extended result
//   rsp_id        [ID_W]           requester that produced rsp_data
//   rsp_ready     [1]              consumer accepts the response
//   dbg_state_o   [1]              occupancy state (EMPTY/FULL)
//   dbg_rr_ptr_o  [ID_W]           round-robin search start
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same channel; ready never depends on anything but the
// current state, rsp_ready and req_valid, and data is held while FULL and
// not accepted.
// Optional feature macro: EXT_LUI_EN.
// ----------------------------------------------------------------------------
module ext_share_arbiter
    import ext_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    localparam int ID_W   = calc_id_w(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IMM_W-1:0] req_imm,
    input  logic [NUM_REQ-1:0]       req_signext,
`ifdef EXT_LUI_EN
    input  logic [NUM_REQ-1:0]       req_lui,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [OUT_W-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready,
    output state_e                   dbg_state_o,
    output logic [ID_W-1:0]          dbg_rr_ptr_o
);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   data_q,  data_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;

    logic [ID_W-1:0]    gnt;
    logic               any_valid;
    logic               can_accept;
    logic               xfer;
    logic [IMM_W-1:0]   imm_sel;
    logic               signext_sel;
    logic [OUT_W-1:0]   ext_result;

    assign gnt        = ID_W'(rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ));
    assign any_valid  = |req_valid;
    // Draining and refilling in the same cycle keeps full throughput.
    assign can_accept = (state_q == EMPTY) || rsp_ready;
    // Gating with Reset keeps req_ready low for the whole reset period.
    assign xfer       = Reset && any_valid && can_accept;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign imm_sel     = req_imm[gnt*IMM_W +: IMM_W];
    assign signext_sel = req_signext[gnt];

    imm_ext_core #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i     (imm_sel),
        .signext_i (signext_sel),
`ifdef EXT_LUI_EN
        .lui_i     (req_lui[gnt]),
`endif
        .result_o  (ext_result)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = ext_result;
            id_d    = gnt;
            ptr_d   = (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_data     = data_q;
    assign rsp_id       = id_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = ptr_q;

endmodule

// File: tb/tb_ext_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ext_share_arbiter
// Directed and randomized checks of ext_share_arbiter (NUM_REQ=2, 16->32).
// The reference keeps the accepted-but-unconsumed response in a queue and
// picks grants by smallest round-robin distance from the pointer.
// Optional feature macro: EXT_LUI_EN (adds the upper-immediate checks).
// ----------------------------------------------------------------------------
module tb_ext_share_arbiter;
    import ext_arb_pkg::*;

    localparam int N   = 2;
    localparam int IW  = 16;
    localparam int OW  = 32;
    localparam int IDW = 1;

    logic              Clk;
    logic              Reset;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_imm;
    logic [N-1:0]      req_signext;
`ifdef EXT_LUI_EN
    logic [N-1:0]      req_lui;
`endif
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [OW-1:0]     rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    state_e            dbg_state;
    logic [IDW-1:0]    dbg_ptr;

    ext_share_arbiter #(
        .NUM_REQ (N),
        .IMM_W   (IW),
        .OUT_W   (OW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_imm      (req_imm),
        .req_signext  (req_signext),
`ifdef EXT_LUI_EN
        .req_lui      (req_lui),
`endif
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_ready    (rsp_ready),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_ptr)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard / reference ----------------
    logic [IDW+OW-1:0] exp_q[$];
    int                m_ptr;
    bit                m_clean;
    int                n_checks;
    int                n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] ref_ext(input logic [IW-1:0] imm, input bit se, input bit lui);
        longint v;
        if (lui)
            v = longint'(imm) * (longint'(1) << (OW - IW));
        else if (se && (longint'(imm) >= (longint'(1) << (IW - 1))))
            v = longint'(imm) - (longint'(1) << IW);
        else
            v = longint'(imm);
        return v[OW-1:0];
    endfunction

    // Valid requester with the smallest forward distance from ptr, or -1.
    function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*IW-1:0] imm,
                        input logic [N-1:0] se, input logic [N-1:0] lui, input bit rr);
        int              g;
        bit              can;
        bit              lui_eff;
        logic [N-1:0]    exp_rdy;
        logic [IW-1:0]   gimm;
        logic [IDW+OW-1:0] e;
        Reset       = rst;
        req_valid   = v;
        req_imm     = imm;
        req_signext = se;
        rsp_ready   = rr;
`ifdef EXT_LUI_EN
        req_lui     = lui;
`endif
        #1;
        g   = ref_pick(v, m_ptr);
        can = (exp_q.size() == 0) || rr;
        exp_rdy = (rst && (g >= 0) && can) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));

        @(posedge Clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            m_ptr   = 0;
            m_clean = 1'b1;
        end else begin
            if ((exp_q.size() != 0) && rr)
                void'(exp_q.pop_front());
            if (exp_rdy != '0) begin
                gimm = imm[g*IW +: IW];
`ifdef EXT_LUI_EN
                lui_eff = lui[g];
`else
                lui_eff = 1'b0;
`endif
                exp_q.push_back({IDW'(g), ref_ext(gimm, se[g], lui_eff)});
                m_ptr   = (g + 1) % N;
                m_clean = 1'b0;
            end
        end

        chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("rsp_data", 64'(rsp_data), 64'(e[OW-1:0]));
            chk("rsp_id", 64'(rsp_id), 64'(e[IDW+OW-1:OW]));
        end else if (m_clean) begin
            chk("rsp_data_rst", 64'(rsp_data), 64'd0);
            chk("rsp_id_rst", 64'(rsp_id), 64'd0);
        end
        chk("rr_ptr", 64'(dbg_ptr), 64'(m_ptr));
        chk("state", 64'(dbg_state), 64'((exp_q.size() != 0) ? FULL : EMPTY));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0]    rv;
        logic [N*IW-1:0] rimm;
        logic [N-1:0]    rse;
        logic [N-1:0]    rlui;
        n_checks = 0;
        n_fail   = 0;
        m_ptr    = 0;
        m_clean  = 1'b1;
        Reset       = 1'b0;
        req_valid   = '0;
        req_imm     = '0;
        req_signext = '0;
        rsp_ready   = 1'b0;
`ifdef EXT_LUI_EN
        req_lui     = '0;
`endif

        // Reset for two cycles with requests asserted: nothing may be granted.
        step(1'b0, 2'b11, {16'h1111, 16'h2222}, 2'b00, 2'b00, 1'b1);
        step(1'b0, 2'b11, {16'h1111, 16'h2222}, 2'b00, 2'b00, 1'b1);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_data", 64'(rsp_data), 64'd0);

        // Idle: pointer must not move.
        step(1'b1, 2'b00, '0, 2'b00, 2'b00, 1'b1);
        step(1'b1, 2'b00, '0, 2'b00, 2'b00, 1'b1);
        chk("idle_ptr", 64'(dbg_ptr), 64'd0);

        // Single sign- and zero-extend from requester 0.
        step(1'b1, 2'b01, {16'h0000, 16'h8001}, 2'b01, 2'b00, 1'b1);
        chk("se_data", 64'(rsp_data), 64'h0000_0000_FFFF_8001);
        chk("se_id", 64'(rsp_id), 64'd0);
        step(1'b1, 2'b01, {16'h0000, 16'h8001}, 2'b00, 2'b00, 1'b1);
        chk("ze_data", 64'(rsp_data), 64'h0000_0000_0000_8001);

        // Both requesting continuously: pointer is 1, so ids go 1,0,1,0 with no bubble.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b11, {16'hA000, 16'h0005}, 2'b11, 2'b00, 1'b1);
            chk("rr_valid", 64'(rsp_valid), 64'd1);
            chk("rr_id", 64'(rsp_id), (i % 2 == 0) ? 64'd1 : 64'd0);
        end

        // Backpressure on a requester-1 result, then drain+refill from requester 0.
        step(1'b1, 2'b10, {16'h7FFF, 16'h0000}, 2'b10, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, {16'h0000, 16'hFF80}, 2'b01, 2'b00, 1'b0);
            chk("bp_data", 64'(rsp_data), 64'h0000_0000_0000_7FFF);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        step(1'b1, 2'b01, {16'h0000, 16'hFF80}, 2'b01, 2'b00, 1'b1);
        chk("refill_data", 64'(rsp_data), 64'h0000_0000_FFFF_FF80);
        chk("refill_id", 64'(rsp_id), 64'd0);

        // Reset while FULL and stalled.
        step(1'b1, 2'b10, {16'h1234, 16'h0000}, 2'b10, 2'b00, 1'b0);
        step(1'b0, 2'b11, {16'h1234, 16'h5678}, 2'b11, 2'b00, 1'b0);
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_data", 64'(rsp_data), 64'd0);
        chk("midrst_ptr", 64'(dbg_ptr), 64'd0);

`ifdef EXT_LUI_EN
        step(1'b1, 2'b01, {16'h0000, 16'h1234}, 2'b01, 2'b01, 1'b1);
        chk("lui_data", 64'(rsp_data), 64'h0000_0000_1234_0000);
`endif

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            rv   = N'($urandom_range(0, 3));
            rimm = {16'($urandom), 16'($urandom)};
            rse  = N'($urandom_range(0, 3));
            rlui = N'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), rv, rimm, rse, rlui, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
